wb_irqctrl: RTL and testbench

Wishbone-mapped interrupt controller sitting between the SoC peripherals (UART, timer, GPIO) and `wb_ibex_core`. It replaces the core's tied-off `irq_external` and `irq_fast` inputs with driven lines. It latches up to 15 peripheral interrupt sources as edge- or level-triggered pending bits and masks them with a software enable register. It drives the core's external and fast interrupt inputs from registered outputs. It occupies a 16-byte slave slot on the shared-bus interconnect at base `'h10030000`.

---
 rtl/wb_irqctrl_pkg.sv | 16 +
 rtl/wb_irqctrl_if.sv | 19 +
 rtl/wb_irqctrl_src_cell.sv | 54 +++++
 rtl/wb_irqctrl.sv | 124 ++++++++++++
 tb/tb_wb_irqctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_irqctrl_pkg.sv
// irqctrl_pkg: shared constants and types for the wb_irqctrl interrupt controller.
//   IRQ_*_OFS   : register byte offsets inside the 16-byte slave slot
//   IRQ_MAX_SRC : upper bound on the number of interrupt sources
//   irq_type_e  : per-source trigger type (level or edge)
package irqctrl_pkg;
    localparam logic [3:0] IRQ_PENDING_OFS = 4'h0;
    localparam logic [3:0] IRQ_ENABLE_OFS  = 4'h4;
    localparam logic [3:0] IRQ_TYPE_OFS    = 4'h8;
    localparam logic [3:0] IRQ_CLAIM_OFS   = 4'hC;
    localparam int         IRQ_MAX_SRC     = 15;

    typedef enum logic {
        IRQ_LEVEL = 1'b0,
        IRQ_EDGE  = 1'b1
    } irq_type_e;
endpackage

// File: rtl/wb_irqctrl_if.sv
// wb_if: Wishbone pipelined bus, 32-bit data, byte address.
//   master drives cyc/stb/we/adr/sel/dat_i; slave drives dat_o/ack/stall/err.
interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;   // write data, master to slave
    logic [31:0] dat_o;   // read data, slave to master
    logic        ack;
    logic        stall;
    logic        err;

    modport master (output cyc, stb, we, adr, sel, dat_i,
                    input  dat_o, ack, stall, err);
    modport slave  (input  cyc, stb, we, adr, sel, dat_i,
                    output dat_o, ack, stall, err);
endinterface

// File: rtl/wb_irqctrl_src_cell.sv
// irqctrl_src_cell: one interrupt source - optional 2-flop synchronizer,
// previous-sample flop and pending flop.
//   clk, rst     : clock, synchronous active-high reset
//   i_src        : raw source line
//   i_type       : IRQ_EDGE latches rising edges, IRQ_LEVEL tracks the sample
//   i_w1c        : software clear (edge type only)
//   i_claim_clr  : clear from a CLAIM read (edge type only)
//   o_pend       : pending bit
// Build option: IRQCTRL_SYNC_EN adds the synchronizer ahead of edge detection.
module irqctrl_src_cell
    import irqctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_src,
    input  irq_type_e i_type,
    input  logic      i_w1c,
    input  logic      i_claim_clr,
    output logic      o_pend
);
    logic w_samp;
    logic w_set;
    logic r_prev;
    logic r_pend;

`ifdef IRQCTRL_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[0], i_src};
    end
    assign w_samp = r_sync[1];
`else
    assign w_samp = i_src;
`endif

    assign w_set = w_samp & ~r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_prev <= w_samp;
            if (i_type == IRQ_LEVEL)
                r_pend <= w_samp;
            else
                // a new edge outranks a clear landing in the same cycle
                r_pend <= w_set | (r_pend & ~(i_w1c | i_claim_clr));
        end
    end

    assign o_pend = r_pend;
endmodule

// File: rtl/wb_irqctrl.sv
// wb_irqctrl: Wishbone interrupt controller feeding the core's external and
// fast interrupt inputs.
//   clk, rst      : clock, synchronous active-high reset
//   wb            : Wishbone pipelined slave (PENDING/ENABLE/TYPE/CLAIM)
//   irq_src       : NSRC raw interrupt lines, active-high
//   irq_external  : registered OR of enabled pending sources
//   irq_fast      : registered enabled-pending bits, zero above NSRC
// Build option: IRQCTRL_SYNC_EN (see irqctrl_src_cell).
module wb_irqctrl
    import irqctrl_pkg::*;
#(
    parameter int                     NSRC     = 8,
    parameter logic [IRQ_MAX_SRC-1:0] RST_TYPE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_if.slave                    wb,
    input  logic [NSRC-1:0]        irq_src,
    output logic                   irq_external,
    output logic [IRQ_MAX_SRC-1:0] irq_fast
);
    logic                   w_acc, w_wr, w_rd;
    logic [3:0]             w_ofs;
    logic [NSRC-1:0]        w_bm, w_wd;
    logic [NSRC-1:0]        w_pend, w_ep;
    logic [NSRC-1:0]        w_w1c, w_claim_clr;
    logic [IRQ_MAX_SRC-1:0] w_ep_ext;
    logic                   w_claim_hit;
    logic [3:0]             w_claim_idx;
    logic [31:0]            w_rdata;
    logic                   w_unused;

    logic [NSRC-1:0]        r_enable, r_type;
    logic                   r_ack;
    logic [31:0]            r_dat;
    logic                   r_ext;
    logic [IRQ_MAX_SRC-1:0] r_fast;

    assign w_acc = wb.cyc & wb.stb;
    assign w_wr  = w_acc & wb.we;
    assign w_rd  = w_acc & ~wb.we;
    assign w_ofs = {wb.adr[3:2], 2'b00};
    assign w_unused = ^{wb.adr, wb.dat_i, wb.sel};

    // per-bit byte-lane mask and masked write data
    always_comb begin
        w_bm = '0;
        for (int i = 0; i < NSRC; i++) w_bm[i] = wb.sel[i/8];
    end
    assign w_wd = wb.dat_i[NSRC-1:0] & w_bm;

    assign w_ep = w_pend & r_enable;

    // lowest index wins: scan high to low so the last hit is the lowest
    always_comb begin
        w_claim_hit = 1'b0;
        w_claim_idx = '0;
        for (int i = NSRC-1; i >= 0; i--) begin
            if (w_ep[i]) begin
                w_claim_hit = 1'b1;
                w_claim_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_w1c       = '0;
        w_claim_clr = '0;
        w_ep_ext    = '0;
        w_ep_ext[NSRC-1:0] = w_ep;
        if (w_wr && w_ofs == IRQ_PENDING_OFS) w_w1c = w_wd;
        for (int i = 0; i < NSRC; i++)
            w_claim_clr[i] = w_rd && (w_ofs == IRQ_CLAIM_OFS) && w_claim_hit
                             && (w_claim_idx == 4'(i));
    end

    always_comb begin
        w_rdata = '0;
        case (w_ofs)
            IRQ_PENDING_OFS: w_rdata[NSRC-1:0] = w_pend;
            IRQ_ENABLE_OFS:  w_rdata[NSRC-1:0] = r_enable;
            IRQ_TYPE_OFS:    w_rdata[NSRC-1:0] = r_type;
            IRQ_CLAIM_OFS:   w_rdata[3:0]      = w_claim_hit ? w_claim_idx + 4'd1 : 4'd0;
            default:         w_rdata           = '0;
        endcase
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irqctrl_src_cell u_cell (
            .clk         (clk),
            .rst         (rst),
            .i_src       (irq_src[g]),
            .i_type      (irq_type_e'(r_type[g])),
            .i_w1c       (w_w1c[g]),
            .i_claim_clr (w_claim_clr[g]),
            .o_pend      (w_pend[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= '0;
            r_type   <= RST_TYPE[NSRC-1:0];
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_ext    <= 1'b0;
            r_fast   <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_rd ? w_rdata : 32'd0;
            if (w_wr && w_ofs == IRQ_ENABLE_OFS) r_enable <= (r_enable & ~w_bm) | w_wd;
            if (w_wr && w_ofs == IRQ_TYPE_OFS)   r_type   <= (r_type & ~w_bm) | w_wd;
            r_fast <= w_ep_ext;
            r_ext  <= |w_ep;
        end
    end

    assign wb.ack       = r_ack;
    assign wb.dat_o     = r_dat;
    assign wb.stall     = 1'b0;
    assign wb.err       = 1'b0;
    assign irq_external = r_ext;
    assign irq_fast     = r_fast;
endmodule

// File: tb/tb_wb_irqctrl.sv
// tb_wb_irqctrl: directed bench for wb_irqctrl - a register-access vector
// table followed by hand-written interrupt, claim, W1C and reset sequences.
module tb_wb_irqctrl;
    import irqctrl_pkg::*;

`ifdef IRQCTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_src = '0;
    logic        irq_external;
    logic [14:0] irq_fast;
    int          errors = 0;
    int          checks = 0;

    wb_if wbi();

    wb_irqctrl #(.NSRC(8), .RST_TYPE('0)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb           (wbi.slave),
        .irq_src      (irq_src),
        .irq_external (irq_external),
        .irq_fast     (irq_fast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  ofs;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        wbi.cyc = 1'b0; wbi.stb = 1'b0; wbi.we = 1'b0;
        wbi.adr = '0; wbi.sel = '0; wbi.dat_i = '0;
    endtask

    // one single-beat transaction: drive on negedge, accept on posedge
    task automatic bus(input logic we, input logic [3:0] ofs, input logic [31:0] d,
                       input logic [3:0] sel, output logic [31:0] rd);
        @(negedge clk);
        wbi.cyc = 1'b1; wbi.stb = 1'b1; wbi.we = we;
        wbi.adr = 32'h1003_0000 | {28'd0, ofs}; wbi.sel = sel; wbi.dat_i = d;
        @(posedge clk); #1;
        idle_bus();
        chk("ack", {31'd0, wbi.ack}, 32'd1);
        rd = wbi.dat_o;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] ofs, input logic [31:0] exp);
        logic [31:0] rd;
        bus(1'b0, ofs, 32'd0, 4'hF, rd);
        chk(name, rd, exp);
    endtask

    task automatic wr(input logic [3:0] ofs, input logic [31:0] d);
        logic [31:0] rd;
        bus(1'b1, ofs, d, 4'hF, rd);
    endtask

    task automatic pulse(input logic [7:0] m);
        @(negedge clk); irq_src = irq_src | m;
        @(negedge clk); irq_src = irq_src & ~m;
    endtask

    vec_t vt[14];

    initial begin
        logic [31:0] rd;
        idle_bus();

        vt[0]  = '{1'b0, IRQ_PENDING_OFS, 32'h0,    4'hF, 32'h0};
        vt[1]  = '{1'b0, IRQ_ENABLE_OFS,  32'h0,    4'hF, 32'h0};
        vt[2]  = '{1'b0, IRQ_TYPE_OFS,    32'h0,    4'hF, 32'h0};
        vt[3]  = '{1'b0, IRQ_CLAIM_OFS,   32'h0,    4'hF, 32'h0};
        vt[4]  = '{1'b1, IRQ_TYPE_OFS,    32'hFF,   4'hF, 32'h0};
        vt[5]  = '{1'b0, IRQ_TYPE_OFS,    32'h0,    4'hF, 32'hFF};
        vt[6]  = '{1'b1, IRQ_ENABLE_OFS,  32'h1FF,  4'hF, 32'h0};
        vt[7]  = '{1'b0, IRQ_ENABLE_OFS,  32'h0,    4'hF, 32'hFF};
        vt[8]  = '{1'b1, IRQ_ENABLE_OFS,  32'hFF04, 4'h2, 32'h0};   // only byte 1 enabled
        vt[9]  = '{1'b0, IRQ_ENABLE_OFS,  32'h0,    4'hF, 32'hFF};
        vt[10] = '{1'b1, IRQ_ENABLE_OFS,  32'h04,   4'hF, 32'h0};
        vt[11] = '{1'b1, IRQ_CLAIM_OFS,   32'h55,   4'hF, 32'h0};   // ignored
        vt[12] = '{1'b0, IRQ_ENABLE_OFS,  32'h0,    4'hF, 32'h04};
        vt[13] = '{1'b0, IRQ_TYPE_OFS,    32'h0,    4'hF, 32'hFF};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ext",  {31'd0, irq_external}, 32'd0);
        chk("rst_fast", {17'd0, irq_fast}, 32'd0);
        chk("rst_ack",  {31'd0, wbi.ack}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            bus(vt[i].we, vt[i].ofs, vt[i].wd, vt[i].sel, rd);
            if (!vt[i].we) chk($sformatf("vec%0d", i), rd, vt[i].exp);
        end

        // edge pulse on source 2 reaches the outputs after LAT cycles
        @(negedge clk); irq_src[2] = 1'b1;
        @(negedge clk); irq_src[2] = 1'b0;
        chk("lat_early", {31'd0, irq_external}, 32'd0);
        repeat (LAT-2) @(negedge clk);
        chk("lat_early2", {31'd0, irq_external}, 32'd0);
        @(negedge clk);
        chk("lat_ext",  {31'd0, irq_external}, 32'd1);
        chk("lat_fast", {17'd0, irq_fast}, 32'h0004);
        rd_chk("pend_s2", IRQ_PENDING_OFS, 32'h04);
        rd_chk("claim_s2", IRQ_CLAIM_OFS, 32'd3);
        rd_chk("pend_clr", IRQ_PENDING_OFS, 32'h0);
        chk("ext_drop", {31'd0, irq_external}, 32'd0);

        // disabled source latches; enabling later raises the irq
        pulse(8'h80);
        repeat (LAT+1) @(negedge clk);
        chk("dis_ext", {31'd0, irq_external}, 32'd0);
        rd_chk("dis_pend", IRQ_PENDING_OFS, 32'h80);
        wr(IRQ_ENABLE_OFS, 32'h84);
        @(posedge clk); #1;
        chk("en_ext",  {31'd0, irq_external}, 32'd1);
        chk("en_fast", {17'd0, irq_fast}, 32'h0080);
        wr(IRQ_PENDING_OFS, 32'h80);
        rd_chk("w1c_pend", IRQ_PENDING_OFS, 32'h0);

        // claim order: source 1 then 5 then none
        wr(IRQ_ENABLE_OFS, 32'h22);
        pulse(8'h22);
        repeat (LAT+1) @(negedge clk);
        chk("cl_ext", {31'd0, irq_external}, 32'd1);
        rd_chk("claim1", IRQ_CLAIM_OFS, 32'd2);
        rd_chk("cl_pend", IRQ_PENDING_OFS, 32'h20);
        rd_chk("claim2", IRQ_CLAIM_OFS, 32'd6);
        rd_chk("claim3", IRQ_CLAIM_OFS, 32'd0);
        chk("cl_ext_fall", {31'd0, irq_external}, 32'd0);

        // level source 3 ignores W1C and tracks the line
        wr(IRQ_TYPE_OFS, 32'hF7);
        @(negedge clk); irq_src[3] = 1'b1;
        repeat (LAT+1) @(negedge clk);
        rd_chk("lvl_pend", IRQ_PENDING_OFS, 32'h08);
        wr(IRQ_PENDING_OFS, 32'h08);
        rd_chk("lvl_w1c", IRQ_PENDING_OFS, 32'h08);
        @(negedge clk); irq_src[3] = 1'b0;
        repeat (LAT-2) @(negedge clk);
        rd_chk("lvl_drop", IRQ_PENDING_OFS, 32'h0);

        // edge on source 0 coincides with W1C of bit 0: set wins
        wr(IRQ_TYPE_OFS, 32'hFF);
        @(negedge clk); irq_src[0] = 1'b1;
        repeat (LAT-2) @(negedge clk);
        wbi.cyc = 1'b1; wbi.stb = 1'b1; wbi.we = 1'b1;
        wbi.adr = 32'h1003_0000; wbi.sel = 4'hF; wbi.dat_i = 32'h1;
        @(posedge clk); #1;
        idle_bus();
        chk("race_ack", {31'd0, wbi.ack}, 32'd1);
        rd_chk("race_pend", IRQ_PENDING_OFS, 32'h01);
        irq_src[0] = 1'b0;
        wr(IRQ_PENDING_OFS, 32'h01);
        rd_chk("race_clr", IRQ_PENDING_OFS, 32'h0);

        // back-to-back reads give back-to-back acks
        @(negedge clk);
        wbi.cyc = 1'b1; wbi.stb = 1'b1; wbi.we = 1'b0; wbi.sel = 4'hF;
        wbi.adr = 32'h1003_0004;
        @(posedge clk); #1;
        chk("b2b_ack0", {31'd0, wbi.ack}, 32'd1);
        chk("b2b_dat0", wbi.dat_o, 32'h22);
        wbi.adr = 32'h1003_0008;
        @(posedge clk); #1;
        chk("b2b_ack1", {31'd0, wbi.ack}, 32'd1);
        chk("b2b_dat1", wbi.dat_o, 32'hFF);
        idle_bus();

        // reset on the accept edge of a read: no ack, outputs cleared
        pulse(8'h02);
        repeat (LAT+1) @(negedge clk);
        chk("pre_rst_ext", {31'd0, irq_external}, 32'd1);
        irq_src[4] = 1'b1;   // held high through reset, level after reset
        @(negedge clk);
        rst = 1'b1;
        wbi.cyc = 1'b1; wbi.stb = 1'b1; wbi.we = 1'b0; wbi.sel = 4'hF;
        wbi.adr = 32'h1003_0000;
        @(posedge clk); #1;
        chk("mrst_ack",  {31'd0, wbi.ack}, 32'd0);
        chk("mrst_dat",  wbi.dat_o, 32'd0);
        chk("mrst_ext",  {31'd0, irq_external}, 32'd0);
        chk("mrst_fast", {17'd0, irq_fast}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_bus();
        @(posedge clk); #1;
        chk("post_ack", {31'd0, wbi.ack}, 32'd0);
        repeat (LAT-2) @(negedge clk);
        rd_chk("post_pend",  IRQ_PENDING_OFS, 32'h10);
        rd_chk("post_en",    IRQ_ENABLE_OFS, 32'h0);
        rd_chk("post_type",  IRQ_TYPE_OFS, 32'h0);
        rd_chk("post_claim", IRQ_CLAIM_OFS, 32'h0);
        chk("post_ext", {31'd0, irq_external}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
